// File: rtl/multi_cycle_ctrl.sv
// Main control FSM of the multi-cycle CPU: IF -> ID -> EXE -> MEM -> WB.
// All datapath enables are registered; they are decoded from the state being
// entered and so change on the same edge as `state`.
// Optional feature macro: CTRL_HALT_EN (opcode 111111 parks the FSM in HALT).
module multi_cycle_ctrl #(
  parameter int op_width     = 6,
  parameter int alu_op_width = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [op_width-1:0]     opcode,
  input  logic                    zero,
  input  logic                    mem_ready,
  output logic                    pc_write,
  output logic                    ir_write,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic                    reg_write,
  output logic [1:0]              read2_sel,
  output logic [alu_op_width-1:0] alu_op,
  output logic [2:0]              state
);

  localparam logic [op_width-1:0] OP_RADD = op_width'(6'b000000);
  localparam logic [op_width-1:0] OP_ADDI = op_width'(6'b000001);
  localparam logic [op_width-1:0] OP_J    = op_width'(6'b000010);
  localparam logic [op_width-1:0] OP_BEQ  = op_width'(6'b000100);
  localparam logic [op_width-1:0] OP_LW   = op_width'(6'b100011);
  localparam logic [op_width-1:0] OP_SW   = op_width'(6'b101011);
`ifdef CTRL_HALT_EN
  localparam logic [op_width-1:0] OP_HALT = op_width'(6'b111111);
`endif

  localparam logic [alu_op_width-1:0] ALU_ADD   = alu_op_width'(3'b000);
  localparam logic [alu_op_width-1:0] ALU_SUB   = alu_op_width'(3'b001);
  localparam logic [alu_op_width-1:0] ALU_PASSB = alu_op_width'(3'b010);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EXE  = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    C_ILL, C_RADD, C_ADDI, C_J, C_BEQ, C_LW, C_SW, C_HALT
  } cls_e;

  state_e                  cur, nxt;
  cls_e                    dec_cls, cls_q, eff_cls;
  logic [1:0]              dec_r2;
  logic [alu_op_width-1:0] nxt_alu;

  assign state = cur;

  // Opcode decode; only consumed while in ID (latched into cls_q there).
  always_comb begin
    dec_cls = C_ILL;
    unique case (opcode)
      OP_RADD: dec_cls = C_RADD;
      OP_ADDI: dec_cls = C_ADDI;
      OP_J:    dec_cls = C_J;
      OP_BEQ:  dec_cls = C_BEQ;
      OP_LW:   dec_cls = C_LW;
      OP_SW:   dec_cls = C_SW;
`ifdef CTRL_HALT_EN
      OP_HALT: dec_cls = C_HALT;
`endif
      default: dec_cls = C_ILL;
    endcase
  end

  // The opcode is looked at only during ID; later states use the latched class,
  // so opcode changes after ID cannot disturb the running instruction.
  assign eff_cls = (cur == S_ID) ? dec_cls : cls_q;

  // Register-2 select chosen in ID and held until the next ID.
  always_comb begin
    dec_r2 = 2'b10;
    if (dec_cls == C_RADD || dec_cls == C_BEQ) dec_r2 = 2'b00;
    else if (dec_cls == C_SW)                  dec_r2 = 2'b01;
  end

  // Next-state logic.
  always_comb begin
    nxt = cur;
    unique case (cur)
      S_IF:  nxt = mem_ready ? S_ID : S_IF;
      S_ID: begin
        if (eff_cls == C_ILL)       nxt = S_IF;
        else if (eff_cls == C_HALT) nxt = S_HALT;
        else                        nxt = S_EXE;
      end
      S_EXE: begin
        if (eff_cls == C_J || eff_cls == C_BEQ)       nxt = S_IF;
        else if (eff_cls == C_LW || eff_cls == C_SW)  nxt = S_MEM;
        else                                          nxt = S_WB;
      end
      S_MEM: begin
        if (mem_ready) nxt = (eff_cls == C_LW) ? S_WB : S_IF;
        else           nxt = S_MEM;
      end
      S_WB:   nxt = S_IF;
      S_HALT: nxt = S_HALT;
      default: nxt = S_IF;
    endcase
  end

  // ALU operation for the state being entered (only meaningful in EXE).
  always_comb begin
    nxt_alu = ALU_ADD;
    if (nxt == S_EXE) begin
      if (eff_cls == C_BEQ)    nxt_alu = ALU_SUB;
      else if (eff_cls == C_J) nxt_alu = ALU_PASSB;
    end
  end

  // State register plus registered enables decoded from the entered state;
  // the fetch strobes (ir_write/pc_write) therefore show during the ID cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur       <= S_IF;
      cls_q     <= C_ILL;
      pc_write  <= 1'b0;
      ir_write  <= 1'b0;
      mem_read  <= 1'b1;
      mem_write <= 1'b0;
      reg_write <= 1'b0;
      read2_sel <= 2'b10;
      alu_op    <= ALU_ADD;
    end else begin
      cur <= nxt;
      if (cur == S_ID) begin
        cls_q     <= dec_cls;
        read2_sel <= dec_r2;
      end
      pc_write  <= (nxt == S_ID) ||
                   (nxt == S_EXE && (eff_cls == C_J || (eff_cls == C_BEQ && zero)));
      ir_write  <= (nxt == S_ID);
      mem_read  <= (nxt == S_IF) || (nxt == S_MEM && eff_cls == C_LW);
      mem_write <= (nxt == S_MEM && eff_cls == C_SW);
      reg_write <= (nxt == S_WB);
      alu_op    <= nxt_alu;
    end
  end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Self-checking bench for multi_cycle_ctrl: directed instructions followed by
// a random instruction stream, checked cycle by cycle against an
// instruction-level model of the expected state trace and enables.
module tb_multi_cycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, ir_write, mem_read, mem_write, reg_write;
  logic [1:0] read2_sel;
  logic [2:0] alu_op;
  logic [2:0] state;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [1:0]  exp_r2;

  multi_cycle_ctrl #(.op_width(6), .alu_op_width(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .zero      (zero),
    .mem_ready (mem_ready),
    .pc_write  (pc_write),
    .ir_write  (ir_write),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .reg_write (reg_write),
    .read2_sel (read2_sel),
    .alu_op    (alu_op),
    .state     (state)
  );

  always #5 clk = ~clk;

  typedef enum int { K_ILL, K_RADD, K_ADDI, K_J, K_BEQ, K_LW, K_SW, K_HALT } kind_e;

  function automatic kind_e kind_of(input logic [5:0] op);
    case (op)
      6'b000000: return K_RADD;
      6'b000001: return K_ADDI;
      6'b000010: return K_J;
      6'b000100: return K_BEQ;
      6'b100011: return K_LW;
      6'b101011: return K_SW;
`ifdef CTRL_HALT_EN
      6'b111111: return K_HALT;
`endif
      default:   return K_ILL;
    endcase
  endfunction

  // Expected enables packed as {pc_write, ir_write, mem_read, mem_write, reg_write, read2_sel, alu_op}.
  function automatic logic [9:0] pack(input logic pcw, input logic irw, input logic mr,
                                      input logic mw, input logic rw, input logic [1:0] r2,
                                      input logic [2:0] alu);
    return {pcw, irw, mr, mw, rw, r2, alu};
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: check this cycle's state/enables, then drive this cycle's inputs.
  task automatic cycle(input string tag, input logic [2:0] est, input logic [9:0] eouts,
                       input logic mr, input logic hold_op, input logic [5:0] op,
                       input logic z, input logic rst);
    @(negedge clk);
    check({tag, "/state"}, 16'(state), 16'(est));
    check({tag, "/enables"},
          16'({pc_write, ir_write, mem_read, mem_write, reg_write, read2_sel, alu_op}),
          16'(eouts));
    reset     = rst;
    mem_ready = mr;
    opcode    = hold_op ? op : 6'($urandom);
    zero      = hold_op ? z : 1'($urandom);
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    mem_ready = 1'($urandom);
    opcode    = 6'($urandom);
    zero      = 1'($urandom);
    @(posedge clk);
    exp_r2 = 2'b10;
  endtask

  // Expected behaviour of one instruction: IF waits for mem_ready, ID is one
  // cycle, EXE one cycle, MEM waits for mem_ready, WB one cycle.
  task automatic run_instr(input logic [5:0] op, input logic z, input int unsigned si,
                           input int unsigned sm, input bit rst_mem);
    kind_e      k;
    logic       pcw;
    logic [2:0] alu;
    k = kind_of(op);
    for (int unsigned i = 0; i <= si; i++)
      cycle("IF", 3'd0, pack(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, exp_r2, 3'd0),
            (i == si), 1'b0, op, z, 1'b0);
    cycle("ID", 3'd1, pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, exp_r2, 3'd0),
          1'($urandom), 1'b1, op, z, 1'b0);
    exp_r2 = (k == K_RADD || k == K_BEQ) ? 2'b00 : (k == K_SW) ? 2'b01 : 2'b10;
    if (k == K_ILL) return;
    if (k == K_HALT) begin
      for (int unsigned i = 0; i < 12; i++)
        cycle("HALT", 3'd5, pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_r2, 3'd0),
              1'($urandom), 1'b0, op, z, 1'b0);
      do_reset();
      return;
    end
    alu = (k == K_BEQ) ? 3'b001 : (k == K_J) ? 3'b010 : 3'b000;
    pcw = (k == K_J) || (k == K_BEQ && z);
    cycle("EXE", 3'd2, pack(pcw, 1'b0, 1'b0, 1'b0, 1'b0, exp_r2, alu),
          1'($urandom), 1'b1, op, z, 1'b0);
    if (k == K_J || k == K_BEQ) return;
    if (k == K_LW || k == K_SW) begin
      for (int unsigned i = 0; i <= sm; i++) begin
        if (rst_mem) begin
          cycle("MEM", 3'd3, pack(1'b0, 1'b0, k == K_LW, k == K_SW, 1'b0, exp_r2, 3'd0),
                1'($urandom), 1'b0, op, z, 1'b1);
          exp_r2 = 2'b10;
          return;
        end
        cycle("MEM", 3'd3, pack(1'b0, 1'b0, k == K_LW, k == K_SW, 1'b0, exp_r2, 3'd0),
              (i == sm), 1'b0, op, z, 1'b0);
      end
      if (k == K_SW) return;
    end
    cycle("WB", 3'd4, pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, exp_r2, 3'd0),
          1'($urandom), 1'b0, op, z, 1'b0);
  endtask

  logic [5:0] legal_ops [6] = '{6'b000000, 6'b000001, 6'b000010, 6'b000100, 6'b100011, 6'b101011};

  initial begin
    reset     = 1'b1;
    mem_ready = 1'b0;
    opcode    = '0;
    zero      = 1'b0;
    exp_r2    = 2'b10;
    repeat (2) @(posedge clk);
    do_reset();

    run_instr(6'b000000, 1'b0, 0, 0, 1'b0);  // R-ADD, no stalls
    run_instr(6'b100011, 1'b0, 0, 2, 1'b0);  // LW, two MEM stalls
    run_instr(6'b000100, 1'b1, 0, 0, 1'b0);  // BEQ taken
    run_instr(6'b000100, 1'b0, 0, 0, 1'b0);  // BEQ not taken
    run_instr(6'b101011, 1'b0, 1, 1, 1'b0);  // SW with IF and MEM stalls
    run_instr(6'b101011, 1'b0, 0, 2, 1'b1);  // SW aborted by reset in MEM
    run_instr(6'b000010, 1'b0, 0, 0, 1'b0);  // J
    run_instr(6'b000001, 1'b0, 2, 0, 1'b0);  // ADDI, IF stalls
    run_instr(6'b111111, 1'b0, 0, 0, 1'b0);  // NOP or HALT depending on build
    run_instr(6'b110000, 1'b0, 0, 0, 1'b0);  // illegal

    for (int unsigned n = 0; n < 300; n++) begin
      logic [5:0]  op;
      int unsigned sel;
      sel = $urandom_range(0, 9);
      if (sel < 6)       op = legal_ops[sel];
      else if (sel == 6) op = 6'b111111;
      else               op = 6'($urandom);
      run_instr(op, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                ($urandom_range(0, 9) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
